// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling from a down-counting baud timer.
// Holds one received byte with valid/ready handshake, frame-error pulse and sticky overrun.
module uart_rx #(
  parameter int unsigned CLK_CYCLES = 100_000_000,
  parameter int unsigned BAUD_RATE  = 19200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       rx_ready_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       is_receiving_o
);

  localparam int unsigned ONE_BAUD = CLK_CYCLES / BAUD_RATE;
  localparam int unsigned HALF     = ONE_BAUD / 2;
  localparam int unsigned TIMER_W  = (ONE_BAUD > 2) ? $clog2(ONE_BAUD) : 1;

  localparam logic [TIMER_W-1:0] HalfLoad = TIMER_W'(HALF - 1);
  localparam logic [TIMER_W-1:0] BaudLoad = TIMER_W'(ONE_BAUD - 1);

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  rx_state_e          state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic               rx_meta_q;
  logic               rx_s;
  logic [7:0]         byte_q;
  logic               valid_q;
  logic               frame_err_q;
  logic               overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RxIdle;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s        <= 1'b1;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s        <= rx_meta_q;
      frame_err_q <= 1'b0;

      // A delivery later in this block overrides the consume when both happen together.
      if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        RxIdle: begin
          if (!rx_s) begin
            timer_q <= HalfLoad;
            state_q <= RxStart;
          end
        end
        RxStart: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else if (!rx_s) begin
            timer_q   <= BaudLoad;
            bit_cnt_q <= '0;
            state_q   <= RxData;
          end else begin
            state_q <= RxIdle;
          end
        end
        RxData: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else begin
            shift_q   <= {rx_s, shift_q[7:1]};
            timer_q   <= BaudLoad;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= RxStop;
            end
          end
        end
        RxStop: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else if (rx_s) begin
            state_q <= RxIdle;
            if (!valid_q || rx_ready_i) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= RxBreak;
          end
        end
        RxBreak: begin
          if (rx_s) begin
            state_q <= RxIdle;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign rx_byte_o      = byte_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = frame_err_q;
  assign rx_overrun_o   = overrun_q;
  assign is_receiving_o = (state_q != RxIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed table, corner sequences,
// and random frames scored against a frame-level model of the receive buffer.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic [7:0] rx_byte_o;
  logic       rx_valid_o;
  logic       rx_frame_err_o;
  logic       rx_overrun_o;
  logic       is_receiving_o;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;

  uart_rx #(
    .CLK_CYCLES(16),
    .BAUD_RATE (1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .rx_ready_i    (rx_ready_i),
    .rx_byte_o     (rx_byte_o),
    .rx_valid_o    (rx_valid_o),
    .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o  (rx_overrun_o),
    .is_receiving_o(is_receiving_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts every cycle the error pulse is high, so a stretched pulse shows up as extra counts.
  always @(negedge clk_i) begin
    if (rx_frame_err_o === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    rx_ready_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte"}, {24'd0, rx_byte_o}, 32'h00);
    check({tag, "_valid"}, {31'd0, rx_valid_o}, 32'd0);
    check({tag, "_ferr"}, {31'd0, rx_frame_err_o}, 32'd0);
    check({tag, "_ovr"}, {31'd0, rx_overrun_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, is_receiving_o}, 32'd0);
  endtask

  task automatic consume();
    @(posedge clk_i);
    #1 rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rx_ready_i = 1'b0;
  endtask

  // Start bit is driven just after edge E-1; the stop-bit sample edge is E154, so
  // ready_at_stop raises rx_ready_i for exactly that edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int low_extra,
                            input logic ready_at_stop);
    @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (16) @(posedge clk_i);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = d[i];
      repeat (16) @(posedge clk_i);
    end
    #1 rx_i = stop;
    if (stop && ready_at_stop) begin
      repeat (10) @(posedge clk_i);
      #1 rx_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rx_ready_i = 1'b0;
      repeat (5) @(posedge clk_i);
    end else if (stop) begin
      repeat (16) @(posedge clk_i);
    end else begin
      repeat (16 + low_extra / 2) @(posedge clk_i);
      @(negedge clk_i);
      check("busy_in_break", {31'd0, is_receiving_o}, 32'd1);
      repeat (low_extra - low_extra / 2) @(posedge clk_i);
    end
    #1 rx_i = 1'b1;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check("idle_after_frame", {31'd0, is_receiving_o}, 32'd0);
  endtask

  typedef struct {
    logic       rst_before;
    logic       consume_before;
    logic [7:0] data;
    logic       stop;
    int         low_extra;
    logic       ready_at_stop;
    logic [7:0] exp_byte;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  // Frame-level model of the one-byte receive buffer.
  logic [7:0] m_byte;
  logic       m_valid;
  logic       m_ovr;

  initial begin
    int f0;
    logic [7:0] d;
    logic stop;
    logic cons;
    int extra;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 0,  1'b0, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 40, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b0, 8'h11, 1'b1, 0,  1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 8'h22, 1'b1, 0,  1'b0, 8'h11, 1'b1, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b1, 8'h5A, 1'b1, 0,  1'b0, 8'h5A, 1'b1, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 8'h11, 1'b1, 0,  1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 8'h22, 1'b1, 0,  1'b1, 8'h22, 1'b1, 1'b0, 0};

    repeat (3) @(posedge clk_i);
    do_reset();
    check_reset_values("reset");

    // Byte held until consumed, then valid drops the cycle after ready.
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    repeat (50) @(posedge clk_i);
    @(negedge clk_i);
    check("hold_byte", {24'd0, rx_byte_o}, 32'hA5);
    check("hold_valid", {31'd0, rx_valid_o}, 32'd1);
    @(posedge clk_i);
    #1 rx_ready_i = 1'b1;
    @(negedge clk_i);
    check("valid_before_ready_edge", {31'd0, rx_valid_o}, 32'd1);
    @(posedge clk_i);
    #1 rx_ready_i = 1'b0;
    @(negedge clk_i);
    check("valid_after_consume", {31'd0, rx_valid_o}, 32'd0);

    // Short low glitch must not start a frame.
    f0 = ferr_seen;
    @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("glitch_busy", {31'd0, is_receiving_o}, 32'd1);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("glitch_idle", {31'd0, is_receiving_o}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid_o}, 32'd0);
    check("glitch_ferr", ferr_seen - f0, 32'd0);
    check("glitch_ovr", {31'd0, rx_overrun_o}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_before) do_reset();
      if (vecs[i].consume_before) consume();
      f0 = ferr_seen;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].low_extra, vecs[i].ready_at_stop);
      check($sformatf("vec%0d_byte", i), {24'd0, rx_byte_o}, {24'd0, vecs[i].exp_byte});
      check($sformatf("vec%0d_valid", i), {31'd0, rx_valid_o}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_ovr", i), {31'd0, rx_overrun_o}, {31'd0, vecs[i].exp_ovr});
      check($sformatf("vec%0d_ferr", i), ferr_seen - f0, vecs[i].exp_ferr);
    end

    // Reset in the middle of data bit 4 of 0xFF aborts the frame.
    f0 = ferr_seen;
    @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (16) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (64 + 8) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_values("midframe_rst");
    repeat (200) @(posedge clk_i);
    @(negedge clk_i);
    check("aborted_no_byte", {31'd0, rx_valid_o}, 32'd0);
    check("aborted_no_ferr", ferr_seen - f0, 32'd0);
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    check("after_rst_byte", {24'd0, rx_byte_o}, 32'h5A);
    check("after_rst_valid", {31'd0, rx_valid_o}, 32'd1);

    // Random frames against the buffer model.
    do_reset();
    m_byte = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      cons = 1'($urandom_range(0, 1));
      extra = int'($urandom_range(0, 20));
      if (cons) begin
        consume();
        m_valid = 1'b0;
      end
      f0 = ferr_seen;
      send_frame(d, stop, extra, 1'b0);
      if (stop) begin
        if (!m_valid) begin
          m_byte = d;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      check($sformatf("rnd%0d_byte", n), {24'd0, rx_byte_o}, {24'd0, m_byte});
      check($sformatf("rnd%0d_valid", n), {31'd0, rx_valid_o}, {31'd0, m_valid});
      check($sformatf("rnd%0d_ovr", n), {31'd0, rx_overrun_o}, {31'd0, m_ovr});
      check($sformatf("rnd%0d_ferr", n), ferr_seen - f0, stop ? 32'd0 : 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_CYCLES, default 100_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 19200, line bit rate in bits/s.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk_i, input, 1 bit, sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port rx_i, input, 1 bit, asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_ready_i, input, 1 bit, consumer accepts rx_byte_o this cycle.
REQ-008 The block SHALL have port rx_byte_o, output, 8 bits, last received byte.
REQ-009 The block SHALL have port rx_valid_o, output, 1 bit, rx_byte_o holds an unconsumed byte.
REQ-010 The block SHALL have port rx_frame_err_o, output, 1 bit, one-cycle pulse on bad stop bit.
REQ-011 The block SHALL have port rx_overrun_o, output, 1 bit, sticky flag for a byte lost while rx_valid_o was high.
REQ-012 The block SHALL have port is_receiving_o, output, 1 bit, high in any state other than RX_IDLE.

Function
REQ-013 The block SHALL derive ONE_BAUD = CLK_CYCLES/BAUD_RATE and HALF = ONE_BAUD/2 (integer division), and size the timer by log2 of ONE_BAUD.
REQ-014 The block SHALL pass rx_i through a two-flop synchronizer, both flops resetting to 1; all decisions use the second flop (rx_s).
REQ-015 The block SHALL implement states RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK.
REQ-016 In RX_IDLE, rx_s = 0 SHALL load timer = HALF-1 and enter RX_START.
REQ-017 In RX_START at timer 0: rx_s = 0 SHALL load timer = ONE_BAUD-1, clear bit count, and enter RX_DATA; rx_s = 1 (glitch) SHALL return to RX_IDLE with no output change.
REQ-018 In RX_DATA at each timer 0 the block SHALL shift rx_s into bit 7 of the shift register (shift right, LSB first on the line) and reload timer = ONE_BAUD-1; after the 8th sample it SHALL enter RX_STOP.
REQ-019 Sample instants SHALL fall HALF + k*ONE_BAUD cycles after RX_START entry: k = 1..8 for data, k = 9 for stop.
REQ-020 In RX_STOP at timer 0 with rx_s = 1, the block SHALL enter RX_IDLE and deliver the byte per REQ-022 to REQ-024.
REQ-021 In RX_STOP at timer 0 with rx_s = 0, the block SHALL discard the byte, pulse rx_frame_err_o for one cycle, and enter RX_BREAK; RX_BREAK SHALL hold until rx_s = 1, then enter RX_IDLE.
REQ-022 Delivery with rx_valid_o = 0 SHALL load rx_byte_o and set rx_valid_o the next cycle.
REQ-023 rx_valid_o & rx_ready_i SHALL clear rx_valid_o the next cycle; rx_byte_o SHALL stay stable while rx_valid_o = 1 and not consumed.
REQ-024 Delivery in the same cycle as a consume SHALL load the new byte and keep rx_valid_o = 1 with no overrun; delivery while rx_valid_o = 1 and not consumed SHALL drop the new byte, keep the old one, and set rx_overrun_o.
REQ-025 rx_overrun_o SHALL clear only on reset.
REQ-026 rx_ready_i while rx_valid_o = 0 SHALL have no effect.

Reset
REQ-027 With rst_i high at a clock edge, the next cycle SHALL show state RX_IDLE, timer 0, synchronizer flops 1, rx_byte_o 8'h00, rx_valid_o 0, rx_frame_err_o 0, rx_overrun_o 0, is_receiving_o 0.
REQ-028 Reset SHALL take priority over all activity; reset mid-frame SHALL abort the frame and deliver no byte.
REQ-029 After reset deasserts, a line already low SHALL be treated as a start bit only after rx_s reads 0.

Verification (bench uses CLK_CYCLES=16, BAUD_RATE=1, so ONE_BAUD=16 and HALF=8)
REQ-030 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with rx_ready_i=0 -> rx_byte_o=8'hA5 and rx_valid_o=1, held until rx_ready_i=1, then rx_valid_o=0 the next cycle.
REQ-031 4-cycle low glitch on an idle line -> return to RX_IDLE, rx_valid_o stays 0, no error flags.
REQ-032 Frame 0x3C with stop bit 0, line held low 40 cycles and then high -> one-cycle rx_frame_err_o pulse, rx_valid_o stays 0, is_receiving_o high until the line returns high.
REQ-033 Frames 0x11 then 0x22 with no rx_ready_i -> rx_byte_o stays 8'h11 and rx_overrun_o=1; with rx_ready_i asserted in the 0x22 delivery cycle instead -> rx_byte_o=8'h22, rx_overrun_o=0.
REQ-034 rst_i asserted in the middle of data bit 4 of frame 0xFF -> all outputs return to reset values and no byte is delivered; the next 0x5A frame is received correctly.
